// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register so that frames can run back to back.
// Latency: 1 clk from accept to start bit. Backpressure: tx_ready drops while the hold register is occupied.
module uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic [3:0] bit_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       shift;
    logic [7:0]       hold;
    logic             hold_full;
    logic             accept;
    logic             bit_end;

    assign tx_ready = !hold_full;
    assign accept   = tx_valid && tx_ready;
    assign busy     = (state != IDLE);
    assign bit_end  = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            shift     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            tx        <= 1'b1;
            bit_count <= 4'd0;
        end else begin
            // Counter idles at 0, so every START begins a full bit period.
            if (state == IDLE || bit_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        shift     <= tx_data;
                        state     <= START;
                        tx        <= 1'b0;
                        bit_count <= 4'd0;
                    end
                end
                START: begin
                    if (accept) begin
                        hold      <= tx_data;
                        hold_full <= 1'b1;
                    end
                    if (bit_end) begin
                        state <= DATA;
                        tx    <= shift[0];
                    end
                end
                DATA: begin
                    if (accept) begin
                        hold      <= tx_data;
                        hold_full <= 1'b1;
                    end
                    if (bit_end) begin
                        shift     <= {1'b0, shift[7:1]};
                        bit_count <= bit_count + 4'd1;
                        if (bit_count == 4'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            tx <= shift[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bit_count <= 4'd0;
                        // A byte accepted on this very edge bypasses the hold register.
                        if (hold_full) begin
                            shift     <= hold;
                            hold_full <= 1'b0;
                            state     <= START;
                            tx        <= 1'b0;
                        end else if (accept) begin
                            shift <= tx_data;
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else if (accept) begin
                        hold      <= tx_data;
                        hold_full <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: directed bytes feed a scoreboard queue, and a line monitor decodes frames and compares them.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic [3:0] bit_count;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx        (tx),
        .busy      (busy),
        .bit_count (bit_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] b;
        bit         b2b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line monitor: samples tx on falling edges, decodes each frame and pops the scoreboard.
    int         cyc      = 0;
    int         mst      = 0;
    int         mcnt     = 0;
    int         mbit     = 0;
    int         stop_end = -100;
    bit         shape_bad;
    logic [7:0] mbyte;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            mst = 0;
        end else begin
            case (mst)
                0: if (tx === 1'b0) begin
                    mst       = 1;
                    mcnt      = 1;
                    shape_bad = 1'b0;
                    if (exp_q.size() > 0 && exp_q[0].b2b)
                        chk("b2b_gap", cyc, stop_end + 1);
                end
                1: begin
                    if (tx !== 1'b0) shape_bad = 1'b1;
                    mcnt++;
                    if (mcnt == CPB) begin
                        mst  = 2;
                        mcnt = 0;
                        mbit = 0;
                    end
                end
                2: begin
                    if (mcnt == 0) mbyte[mbit] = tx;
                    else if (tx !== mbyte[mbit]) shape_bad = 1'b1;
                    mcnt++;
                    if (mcnt == CPB) begin
                        mcnt = 0;
                        mbit++;
                        if (mbit == 8) mst = 3;
                    end
                end
                default: begin
                    if (tx !== 1'b1) shape_bad = 1'b1;
                    mcnt++;
                    if (mcnt == CPB) begin
                        mst      = 0;
                        stop_end = cyc;
                        chk("frame_shape", shape_bad, 0);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_frame", mbyte, 8'hxx);
                        end else begin
                            chk("frame_data", mbyte, exp_q[0].b);
                            void'(exp_q.pop_front());
                        end
                    end
                end
            endcase
        end
    end

    task automatic send(input logic [7:0] b, input bit b2b, input bit push);
        int n = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", (n < 1000), 1);
        @(posedge clk);
        if (push) exp_q.push_back('{b, b2b});
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", (n < 2000), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_bc(input logic [3:0] v);
        int n = 0;
        @(negedge clk);
        while (bit_count != v && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("bit_count_timeout", (n < 500), 1);
    endtask

    initial begin
        int busy_cnt;
        int ready_low;
        int bc_bad;
        int n;
        logic [3:0] bc_exp;

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Asynchronous reset, checked before the first clock edge.
        #2 reset = 1'b0;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_bit_count", bit_count, 0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_tx_after_release", tx, 1);

        // Single byte with per-cycle busy / ready / bit_count profile.
        send(8'hA5, 1'b0, 1'b1);
        busy_cnt  = 0;
        ready_low = 0;
        bc_bad    = 0;
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (!tx_ready) ready_low++;
            if (k <= 4 || k > 40) bc_exp = 4'd0;
            else if (k <= 36) bc_exp = 4'((k - 5) / 4);
            else bc_exp = 4'd8;
            if (bit_count !== bc_exp) bc_bad++;
        end
        chk("single_busy_cycles", busy_cnt, 40);
        chk("single_ready_low", ready_low, 0);
        chk("single_bit_count_bad", bc_bad, 0);
        wait_idle();

        // Back to back: second byte lands in the hold register.
        send(8'h00, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        send(8'hFF, 1'b1, 1'b1);
        @(negedge clk);
        chk("b2b_ready_low", tx_ready, 0);
        n = 0;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_ready_timeout", (n < 200), 1);
        chk("b2b_tx_start", tx, 0);
        chk("b2b_bit_count", bit_count, 0);
        chk("b2b_busy", busy, 1);
        wait_idle();

        // Hold full: 0x34 waits while 0x12 is held.
        send(8'h81, 1'b0, 1'b1);
        send(8'h12, 1'b1, 1'b1);
        @(negedge clk);
        chk("hold_ready_low", tx_ready, 0);
        send(8'h34, 1'b1, 1'b1);
        wait_idle();

        // Accept on the final STOP edge with the hold register empty.
        send(8'h66, 1'b0, 1'b1);
        wait_bc(4'd8);
        repeat (3) @(negedge clk);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        chk("last_ready", tx_ready, 1);
        chk("last_bit_count", bit_count, 8);
        chk("last_tx_stop", tx, 1);
        @(posedge clk);
        exp_q.push_back('{8'h5A, 1'b1});
        #1 tx_valid = 1'b0;
        @(negedge clk);
        chk("last_tx_start", tx, 0);
        chk("last_busy", busy, 1);
        chk("last_bit_count_zero", bit_count, 0);
        wait_idle();

        // Reset mid-frame aborts 0xC3; 0x3C must follow cleanly.
        send(8'hC3, 1'b0, 1'b0);
        wait_bc(4'd3);
        #2 reset = 1'b0;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_bit_count", bit_count, 0);
        chk("abort_ready", tx_ready, 1);
        @(negedge clk);
        #1 reset = 1'b1;
        send(8'h3C, 1'b0, 1'b1);
        wait_idle();

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
